// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, constants, controller state encoding and the
// operand classifier used to short-circuit special values.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = 14;

  localparam logic [15:0]      FP16_QNAN = 16'h7E00;
  localparam logic [15:0]      FP16_PINF = 16'h7C00;
  localparam logic [15:0]      FP16_NINF = 16'hFC00;
  localparam logic [EXP_W-1:0] EXP_MAX   = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        special;
    logic [15:0] q;
  } special_t;

  // exp==0 counts as zero whatever the fraction holds, so subnormals flush here.
  function automatic special_t classify(input logic [15:0] a, input logic [15:0] b);
    special_t r;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a[14:10] == '0);
    b_zero = (b[14:10] == '0);
    a_inf  = (a[14:10] == EXP_MAX) && (a[9:0] == '0);
    b_inf  = (b[14:10] == EXP_MAX) && (b[9:0] == '0);
    a_nan  = (a[14:10] == EXP_MAX) && (a[9:0] != '0);
    b_nan  = (b[14:10] == EXP_MAX) && (b[9:0] != '0);
    r.special = 1'b1;
    r.q       = FP16_QNAN;
    if (a_nan || b_nan)                       r.q = FP16_QNAN;
    else if (a_inf && b_inf && (a[15] != b[15])) r.q = FP16_QNAN;
    else if (a_inf)                           r.q = a;
    else if (b_inf)                           r.q = b;
    else if (a_zero && b_zero)                r.q = {a[15] & b[15], 15'b0};
    else if (a_zero)                          r.q = b;
    else if (b_zero)                          r.q = a;
    else                                      r.special = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fp16_align_swap.sv
// Orders two normal FP16 operands by magnitude and right-aligns the smaller
// significand to the larger exponent. Shifted-out bits are simply dropped.
module fp16_align_swap
  import fp16_pkg::*;
#(
  parameter int GUARD_BITS = 3,
  parameter int SAT_SHIFT  = 14
) (
  input  logic [15:0]             a_i,
  input  logic [15:0]             b_i,
  output logic [11+GUARD_BITS-1:0] big_m_o,
  output logic [11+GUARD_BITS-1:0] small_m_o,
  output logic [EXP_W-1:0]        exp_big_o,
  output logic                    sign_o,
  output logic                    eff_sub_o
);

  localparam int MW = 11 + GUARD_BITS;

  logic              a_big;
  logic [EXP_W-1:0]  small_exp;
  logic [FRAC_W-1:0] big_frac, small_frac;
  logic [EXP_W-1:0]  shift;
  logic [MW-1:0]     small_full;

  always_comb begin
    // Exact magnitude tie keeps A as the big operand.
    a_big      = (a_i[14:0] >= b_i[14:0]);
    exp_big_o  = a_big ? a_i[14:10] : b_i[14:10];
    small_exp  = a_big ? b_i[14:10] : a_i[14:10];
    big_frac   = a_big ? a_i[9:0]   : b_i[9:0];
    small_frac = a_big ? b_i[9:0]   : a_i[9:0];
    sign_o     = a_big ? a_i[15]    : b_i[15];
    eff_sub_o  = a_i[15] ^ b_i[15];
    shift      = exp_big_o - small_exp;
    big_m_o    = {1'b1, big_frac, {GUARD_BITS{1'b0}}};
    small_full = {1'b1, small_frac, {GUARD_BITS{1'b0}}};
    small_m_o  = (int'(shift) >= SAT_SHIFT) ? '0 : (small_full >> shift);
  end

endmodule

// File: rtl/fp16_add_ctrl.sv
// Multi-cycle FP16 add/subtract controller: classify, align, add, then
// normalize one bit per cycle through a shared mantissa register. Truncating.
module fp16_add_ctrl
  import fp16_pkg::*;
#(
  parameter int GUARD_BITS = 3,
  parameter int SAT_SHIFT  = 14
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_A,
  input  logic [15:0] IN_B,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q,
  output logic        BUSY,
  output state_e      DBG_STATE
);

  localparam int MW = 11 + GUARD_BITS;
  localparam int SW = MW + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; IN_READY is high only in IDLE, OUT_VALID only in DONE.
  state_e           state_q;
  logic [15:0]      a_q, b_q;
  logic [MW-1:0]    big_q, small_q;
  logic [EXP_W-1:0] exp_q;
  logic             sign_q, sub_q;
  logic [SW-1:0]    sum_q;
  logic [15:0]      q_q;
  logic             out_valid_q;

  special_t         special_d;
  logic [MW-1:0]    al_big_m, al_small_m;
  logic [EXP_W-1:0] al_exp_big;
  logic             al_sign, al_sub;
  logic [SW-1:0]    sum_d;
  logic [EXP_W-1:0] exp_inc_d, exp_dec_d;

  fp16_align_swap #(
    .GUARD_BITS(GUARD_BITS),
    .SAT_SHIFT (SAT_SHIFT)
  ) u_align (
    .a_i      (a_q),
    .b_i      (b_q),
    .big_m_o  (al_big_m),
    .small_m_o(al_small_m),
    .exp_big_o(al_exp_big),
    .sign_o   (al_sign),
    .eff_sub_o(al_sub)
  );

  always_comb begin
    special_d = classify(IN_A, IN_B);
    // big >= small by construction, so the difference never wraps.
    sum_d     = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                      : ({1'b0, big_q} + {1'b0, small_q});
    exp_inc_d = exp_q + 5'd1;
    exp_dec_d = exp_q - 5'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      big_q       <= '0;
      small_q     <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      sum_q       <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            a_q <= IN_A;
            b_q <= IN_B;
            if (special_d.special) begin
              q_q         <= special_d.q;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          big_q   <= al_big_m;
          small_q <= al_small_m;
          exp_q   <= al_exp_big;
          sign_q  <= al_sign;
          sub_q   <= al_sub;
          state_q <= ST_ADD;
        end
        ST_ADD: begin
          sum_q <= sum_d;
          if (sum_d == '0) begin
            q_q         <= 16'h0000;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (sum_q[SW-1]) begin
            // Carry: the right shift always lands the leading one on the
            // hidden bit, so the result is emitted in the same cycle.
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
            if (exp_inc_d == EXP_MAX) q_q <= {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
            else                      q_q <= {sign_q, exp_inc_d, sum_q[SW-2 -: FRAC_W]};
          end else if (sum_q[SW-2]) begin
            q_q         <= {sign_q, exp_q, sum_q[SW-3 -: FRAC_W]};
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            sum_q <= sum_q << 1;
            exp_q <= exp_dec_d;
            if (exp_dec_d == '0) begin
              q_q         <= {sign_q, 15'b0};
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign OUT_VALID = out_valid_q;
  assign Q         = q_q;
  assign DBG_STATE = state_q;

endmodule
